mul_dot_acc: RTL and testbench

- Downstream consumer of the unsigned multiplier product P.
- Registers each product behind a valid/ready handshake and accumulates a run of products into a wide sum, i.e. a dot product.
- Presents the finished sum on a second valid/ready handshake.
- Stage 1 isolates the multiplier's combinational path from the accumulator adder.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_dot_acc_if.sv | 26 ++
 rtl/Add.sv | 16 +
 rtl/mul_pipe_reg.sv | 45 ++++
 rtl/mul_dot_acc.sv | 122 ++++++++++++
 tb/tb_mul_dot_acc.sv | 332 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the multiplier-product consumers.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int widthP(input int wx, input int wy);
    return wx + wy;
  endfunction

  function automatic bit acc_fits(input int wa, input int wp);
    return wa >= wp;
  endfunction

endpackage

// File: rtl/mul_dot_acc_if.sv
// Product-in / result-out handshake bundle of the dot-product accumulator.
interface mul_dot_acc_if #(
  parameter int widthP = 32,
  parameter int widthA = 40,
  parameter int widthN = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [widthP-1:0] in_p_i;
  logic              in_last_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [widthA-1:0] out_sum_o;
  logic              out_ovf_o;
  logic [widthN-1:0] out_cnt_o;

  modport slave (
    input  in_valid_i, in_p_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_sum_o, out_ovf_o, out_cnt_o
  );

  modport master (
    output in_valid_i, in_p_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_sum_o, out_ovf_o, out_cnt_o
  );
endinterface

// File: rtl/Add.sv
// Library adder; speed selects the implementation in the full library, this
// slice only carries the behavioural variant.
module Add #(
  parameter int width = 8,
  parameter int speed = 0
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] s_o
);
  if (speed < 0 || speed > 2) begin : g_bad_speed
    $error("Add: unsupported speed setting");
  end

  assign s_o = a_i + b_i;
endmodule

// File: rtl/mul_pipe_reg.sv
// Single-entry valid/ready register; in_ready depends on local state and the
// downstream ready only, never on in_valid.
module mul_pipe_reg #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] out_data_o
);
  logic             valid_q, valid_d;
  logic [width-1:0] data_q, data_d;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/mul_dot_acc.sv
// Dot-product accumulator: registers multiplier products and sums each run,
// presenting sum, product count and wrap flag on a result handshake.
//   state | meaning
//   IDLE  | no run open; accumulator cleared, next product starts a run
//   ACC   | run open, adding products until one carries last
//   HOLD  | result presented; stage 1 is not drained
module mul_dot_acc
  import mul_pkg::*;
#(
  parameter int widthX = 16,
  parameter int widthY = 16,
  parameter int widthA = 40,
  parameter int widthN = 8,
  parameter int speed  = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  mul_dot_acc_if.slave  bus
);
  localparam int WP = widthP(widthX, widthY);

  if (!acc_fits(widthA, WP)) begin : g_bad_width
    $error("mul_dot_acc: accumulator narrower than the product");
  end

  typedef logic [widthA-1:0] acc_t;

  state_e            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [widthN-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic          s1_valid, s1_last, drain, consume;
  logic [WP-1:0] s1_p;
  acc_t          p_ext;
  logic [widthA:0] add_s;

  assign drain   = (state_q != HOLD);
  assign consume = s1_valid & drain;
  assign p_ext   = acc_t'(s1_p);

  mul_pipe_reg #(.width(WP + 1)) u_s1 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .in_valid_i  (bus.in_valid_i),
    .in_ready_o  (bus.in_ready_o),
    .in_data_i   ({bus.in_last_i, bus.in_p_i}),
    .out_valid_o (s1_valid),
    .out_ready_i (drain),
    .out_data_o  ({s1_last, s1_p})
  );

  // One extra bit on both operands exposes the carry out of the accumulator.
  Add #(.width(widthA + 1), .speed(speed)) u_add (
    .a_i ({1'b0, acc_q}),
    .b_i ({1'b0, p_ext}),
    .s_o (add_s)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        if (consume) begin
          acc_d   = p_ext;
          cnt_d   = widthN'(1);
          state_d = s1_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (consume) begin
          acc_d = add_s[widthA-1:0];
          ovf_d = ovf_q | add_s[widthA];
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + widthN'(1);
          if (s1_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid_o = (state_q == HOLD);
  assign bus.out_sum_o   = acc_q;
  assign bus.out_cnt_o   = cnt_q;
  assign bus.out_ovf_o   = ovf_q;
endmodule

// File: tb/tb_mul_dot_acc.sv
// Bench for mul_dot_acc: directed scenarios plus randomized runs checked
// against an arithmetic model of each run's sum, wrap flag and count.
module tb_mul_dot_acc;
  localparam int WA   = 33;
  localparam int WN   = 3;
  localparam int MAXC = (1 << WN) - 1;

  typedef struct {
    logic [31:0] p;
    bit          last;
  } item_t;

  typedef struct {
    longint unsigned sum;
    bit              ovf;
    int              cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  int drv_idx = 0;
  int first_valid_cyc, last_acc_cyc;
  bit pend = 0;

  item_t           drv_q[$];
  res_t            exp_q[$];
  longint unsigned run_vals[$];

  always #5 clk = ~clk;

  mul_dot_acc_if #(.widthP(32), .widthA(WA), .widthN(WN)) bus ();

  mul_dot_acc #(
    .widthX(16), .widthY(16), .widthA(WA), .widthN(WN), .speed(0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a run's result is its plain integer total reduced mod 2**WA; some
  // add carried exactly when that total reached 2**WA.
  task automatic add_run();
    longint unsigned tot;
    int    n;
    item_t it;
    res_t  r;
    tot = 0;
    n = run_vals.size();
    for (int i = 0; i < n; i++) begin
      tot += run_vals[i];
      it.p = 32'(run_vals[i]);
      it.last = (i == n - 1);
      drv_q.push_back(it);
    end
    r.sum = tot % (64'd1 << WA);
    r.ovf = (tot >= (64'd1 << WA));
    r.cnt = (n > MAXC) ? MAXC : n;
    exp_q.push_back(r);
    run_vals.delete();
  endtask

  task automatic run_traffic(input int max_cyc, input bit rnd);
    bit   done;
    res_t e;
    logic [WA-1:0] es;
    logic [WN-1:0] ec;
    done = 0;
    first_valid_cyc = -1;
    last_acc_cyc = -1;
    pend = 0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (drv_idx < drv_q.size()) begin
        if (!pend && rnd && ($urandom_range(0, 3) == 0)) begin
          bus.in_valid_i = 1'b0;
        end else begin
          bus.in_valid_i = 1'b1;
          bus.in_p_i     = drv_q[drv_idx].p;
          bus.in_last_i  = drv_q[drv_idx].last;
        end
      end else begin
        bus.in_valid_i = 1'b0;
      end
      bus.out_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (bus.in_valid_i && bus.in_ready_o) begin
        if (drv_q[drv_idx].last) last_acc_cyc = cyc;
        drv_idx++;
        n_hs++;
        pend = 0;
      end else begin
        pend = bus.in_valid_i;
      end
      if (bus.out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid_o && bus.out_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result sum=%h cnt=%0d (no result outstanding)",
                   bus.out_sum_o, bus.out_cnt_o);
        end else begin
          e = exp_q.pop_front();
          es = e.sum[WA-1:0];
          ec = WN'(e.cnt);
          if (bus.out_sum_o !== es) begin
            n_err++;
            $display("FAIL result_sum got=%h exp=%h", bus.out_sum_o, es);
          end
          n_cmp++;
          if (bus.out_cnt_o !== ec) begin
            n_err++;
            $display("FAIL result_cnt got=%0d exp=%0d", bus.out_cnt_o, ec);
          end
          n_cmp++;
          if (bus.out_ovf_o !== e.ovf) begin
            n_err++;
            $display("FAIL result_ovf got=%b exp=%b", bus.out_ovf_o, e.ovf);
          end
        end
      end
      done = (drv_idx == drv_q.size()) && (exp_q.size() == 0);
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL traffic_timeout got=%0d_results_left exp=0", exp_q.size());
    end
    @(posedge clk);
    #1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    drv_q.delete();
    exp_q.delete();
    drv_idx = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_p_i = '0;
    bus.in_last_i = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid_o); end
    n_cmp++;
    if (bus.out_sum_o !== '0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", bus.out_sum_o); end
    n_cmp++;
    if (bus.out_cnt_o !== '0 || bus.out_ovf_o !== 1'b0) begin
      n_err++; $display("FAIL reset_cnt_ovf got=%0d/%b exp=0/0", bus.out_cnt_o, bus.out_ovf_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
  endtask

  task automatic test_run3();
    run_vals = '{64'd6, 64'd10, 64'd20};
    add_run();
    run_traffic(100, 1'b0);
    n_cmp++;
    if (first_valid_cyc - last_acc_cyc != 2) begin
      n_err++;
      $display("FAIL run3_latency got=%0d exp=2", first_valid_cyc - last_acc_cyc);
    end
    n_cmp++;
    if (bus.out_valid_o !== 1'b0 || bus.out_sum_o !== '0) begin
      n_err++;
      $display("FAIL run3_idle got=%b/%h exp=0/0", bus.out_valid_o, bus.out_sum_o);
    end
  endtask

  task automatic test_hold();
    logic [WA-1:0] exp_s;
    exp_s = WA'(32'hFFFF_FFFE);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_p_i = 32'hFFFF_FFFE;
    bus.in_last_i = 1'b1;
    tick();
    bus.in_p_i = 32'd5;
    tick();
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.out_valid_o !== 1'b1 || bus.out_sum_o !== exp_s || bus.out_cnt_o !== WN'(1)) begin
        n_err++;
        $display("FAIL hold_stable got=%b/%h/%0d exp=1/%h/1", bus.out_valid_o,
                 bus.out_sum_o, bus.out_cnt_o, exp_s);
      end
      n_cmp++;
      if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_in_ready got=%b exp=0", bus.in_ready_o); end
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    n_cmp++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release got=%b/%b exp=0/1", bus.out_valid_o, bus.in_ready_o);
    end
    tick();
    n_cmp++;
    if (bus.out_valid_o !== 1'b1 || bus.out_sum_o !== WA'(5) || bus.out_cnt_o !== WN'(1)) begin
      n_err++;
      $display("FAIL hold_next_run got=%b/%h/%0d exp=1/5/1", bus.out_valid_o,
               bus.out_sum_o, bus.out_cnt_o);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    run_vals = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF};
    add_run();
    run_vals = '{64'd1, 64'd2};
    add_run();
    run_traffic(200, 1'b0);
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = n_hs;
    run_vals = '{64'd1, 64'd2};
    add_run();
    run_vals = '{64'd3, 64'd4};
    add_run();
    run_traffic(200, 1'b0);
    n_cmp++;
    if (n_hs - hs0 != 4) begin n_err++; $display("FAIL b2b_handshakes got=%0d exp=4", n_hs - hs0); end
  endtask

  task automatic test_clear();
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.in_last_i = 1'b0;
    bus.in_p_i = 32'd11;
    tick();
    bus.in_p_i = 32'd12;
    tick();
    bus.in_p_i = 32'd13;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid_i = 1'b0;
    n_cmp++;
    if (bus.out_valid_o !== 1'b0 || bus.out_sum_o !== '0 || bus.out_cnt_o !== '0) begin
      n_err++;
      $display("FAIL clr_state got=%b/%h/%0d exp=0/0/0", bus.out_valid_o, bus.out_sum_o, bus.out_cnt_o);
    end
    n_cmp++;
    if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL clr_in_ready got=%b exp=1", bus.in_ready_o); end
    tick();
    n_cmp++;
    if (bus.out_sum_o !== '0) begin n_err++; $display("FAIL clr_discard got=%h exp=0", bus.out_sum_o); end
    run_vals = '{64'd5, 64'd5};
    add_run();
    run_traffic(100, 1'b0);
  endtask

  task automatic test_async_reset();
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_p_i = 32'd99;
    bus.in_last_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid_o !== 1'b1 || bus.out_sum_o !== WA'(99)) begin
      n_err++; $display("FAIL arst_hold got=%b/%h exp=1/63", bus.out_valid_o, bus.out_sum_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid_o !== 1'b0 || bus.out_sum_o !== '0 || bus.out_cnt_o !== '0) begin
      n_err++;
      $display("FAIL arst_immediate got=%b/%h/%0d exp=0/0/0", bus.out_valid_o, bus.out_sum_o, bus.out_cnt_o);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_vals = '{64'd7};
    add_run();
    run_traffic(100, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 14; r++) begin
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) run_vals.push_back(64'hFFFF_FFFF);
        else run_vals.push_back(longint'($urandom));
      end
      add_run();
    end
    run_traffic(3000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_run3();
    test_hold();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
